alu_param: RTL
==============

# alu_param

Parametrised, registered successor to the team's 4-bit ALU. It covers the same opcode family at a configurable operand width W: add, subtract, increment, decrement, compare, loadable up/down counters and shift-left. It adds bitwise ops, a sequential shift-add multiplier with a busy/done handshake, and a registered flag bus. It sits between the operand registers and the result bus of the datapath.

## Interface
- W, default 4, operand width; legal range 2..16; result width is 2W.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (low = reset)
- in1  input  W  operand A; also the counter load value
- in2  input  W  operand B
- s  input  4  opcode
- ld  input  1  load/execute enable
- out  output  2W  registered result
- flags  output  4  registered {err, c, z, eq}
- busy  output  1  multiplier running
- done  output  1  one-cycle pulse when the product lands in out

## Operation
- Reset (rst=0, asynchronous): out=0, flags=0, busy=0, done=0, internal counter=0, multiplier FSM=IDLE.
- Single-cycle ops register on the rising edge when ld=1. When ld=0, out holds, except in the counter modes. Results are zero-extended to 2W.
  - 0 ADD: in1+in2, W+1 bits.
  - 1 SUB: (in1−in2) mod 2^W; c=borrow (in1<in2).
  - 2 INC: in1+1, W+1 bits.
  - 3 DEC: (in1−1) mod 2^W; c=borrow (in1==0).
  - 4 CMP: out[2:0]={gt,lt,eq}, all other bits 0.
  - 7 SHL: {in1,1'b0}, W+1 bits.
  - 9 AND, 10 OR, 11 XOR: W-bit results.
- Counter modes: 5 UP, 6 DN.
  - ld=1: the counter loads in1.
  - ld=0: the counter steps every clock, ±1 mod 2^W.
  - out[W-1:0]=counter and out[W]=terminal count. Terminal count is counter==all-ones for UP and counter==0 for DN, evaluated on the new value.
- 8 MUL: unsigned W×W→2W, sequential shift-add.
  - FSM has two states, IDLE and RUN.
  - IDLE with ld=1 and s=8: capture in1/in2, clear the accumulator, load iteration count W, go to RUN, busy=1.
  - RUN: one partial-product step per cycle. When the count reaches 0, write the product to out, set done=1 for one cycle, busy=0, return to IDLE.
  - While busy=1, ld, s, in1 and in2 are ignored. out and flags hold their pre-MUL values until the product lands.
- Reserved opcodes 12–15 with ld=1: out holds and flags.err=1. err clears on the next valid op.
- Flags update on every edge that updates out. In counter modes they update every stepping cycle.
  - z = (new out == 0).
  - c = carry (out[W] for ADD/INC/SHL), borrow (SUB/DEC), or terminal count (UP/DN). c=0 for other ops.
  - eq = (in1==in2) for CMP, else 0.

## Timing
- Single-cycle ops and counter loads/steps: result visible in out one clock after the enabling edge.
- MUL latency: the accept edge is E0 and the product appears in out at edge E(W+1). done is high from E(W+1) to E(W+2). busy is high from E0 to E(W+1).
- Back-to-back MUL: a new ld=1, s=8 presented while done=1 is accepted on that edge.
- Opcode change away from UP/DN while ld=0: out holds and the counter freezes at its last value.
- Reset asserted mid-MUL: the operation aborts immediately, busy=0, out=0, and done never pulses.
- Reset deassertion is used synchronously by the design: the first functional edge is the first rising clk with rst=1.

## Test plan
- W=4, reset then ld=1, s=0, in1=0010, in2=1010 -> out=00001100, c=0. Then in1=1110, in2=1011 -> out=00011001, c=1.
- W=4, s=1, in1=0010, in2=1101 -> out=00000101, c=1. Then s=4, in1=in2=0100 -> out=00000001, eq=1.
- W=4, s=5, ld=1 with in1=1101, then ld=0 -> out sequence 00001110, 00011111, 00000000 (z=1). Then s=6 loaded with 0010 -> 00000001, 00010000, 00001111.
- W=4, s=8, in1=1101, in2=1011, ld=1 for one cycle -> busy for 5 cycles, then out=10001111 with a single done pulse. Changing in1 while busy has no effect.
- W=8, s=8, in1=0xFF, in2=0xFF -> out=0xFE01 at edge E9. Assert rst at E4 of a second MUL -> out=0, busy=0, no done pulse.
- W=4, s=13 with ld=1 -> out holds and err=1. Next s=2, in1=1111 -> out=00010000, err=0, c=1.

Source files
------------

// File: rtl/alu_param_if.sv
// Operand/result bus between the datapath operand registers and alu_param.
// The master drives the operands and opcode; the slave (ALU) returns result, flags and handshake.
interface alu_param_if #(
    parameter int W = 4
);
    logic [W-1:0]   in1;
    logic [W-1:0]   in2;
    logic [3:0]     s;
    logic           ld;
    logic [2*W-1:0] out;
    logic [3:0]     flags;
    logic           busy;
    logic           done;

    modport master (
        output in1, in2, s, ld,
        input  out, flags, busy, done
    );

    modport slave (
        input  in1, in2, s, ld,
        output out, flags, busy, done
    );
endinterface

// File: rtl/alu_param.sv
// Registered W-bit ALU: single-cycle arithmetic/logic ops, loadable up/down counter
// and a sequential shift-add multiplier with busy/done handshake. flags = {err, c, z, eq}.
module alu_param #(
    parameter int W = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_param_if.slave bus
);
    localparam int RW = 2 * W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
        OP_CMP = 4'd4, OP_UP  = 4'd5, OP_DN  = 4'd6, OP_SHL = 4'd7,
        OP_MUL = 4'd8, OP_AND = 4'd9, OP_OR  = 4'd10, OP_XOR = 4'd11
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state;
    logic [W-1:0]  cnt;
    logic [RW-1:0] mcand;
    logic [RW-1:0] acc;
    logic [W-1:0]  mplier;
    logic [CW-1:0] iter;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] res;
    logic [W-1:0]  lw;
    logic          res_c;
    logic          res_eq;
    logic          res_valid;
    logic          is_cnt;
    logic [W-1:0]  cnt_nx;
    logic          tc_nx;
    logic [RW-1:0] cnt_out;

    assign a_ext   = RW'(bus.in1);
    assign b_ext   = RW'(bus.in2);
    assign is_cnt  = (bus.s == OP_UP) || (bus.s == OP_DN);
    assign cnt_out = RW'({tc_nx, cnt_nx});

    always_comb begin
        res       = '0;
        lw        = '0;
        res_c     = 1'b0;
        res_eq    = 1'b0;
        res_valid = 1'b1;
        case (bus.s)
            OP_ADD: begin
                res   = a_ext + b_ext;
                res_c = res[W];
            end
            OP_SUB: begin
                lw    = bus.in1 - bus.in2;
                res   = RW'(lw);
                res_c = bus.in1 < bus.in2;
            end
            OP_INC: begin
                res   = a_ext + RW'(1);
                res_c = res[W];
            end
            OP_DEC: begin
                lw    = bus.in1 - W'(1);
                res   = RW'(lw);
                res_c = (bus.in1 == '0);
            end
            OP_CMP: begin
                res[2:0] = {bus.in1 > bus.in2, bus.in1 < bus.in2, bus.in1 == bus.in2};
                res_eq   = (bus.in1 == bus.in2);
            end
            OP_SHL: begin
                res   = a_ext << 1;
                res_c = res[W];
            end
            OP_AND: begin
                lw  = bus.in1 & bus.in2;
                res = RW'(lw);
            end
            OP_OR: begin
                lw  = bus.in1 | bus.in2;
                res = RW'(lw);
            end
            OP_XOR: begin
                lw  = bus.in1 ^ bus.in2;
                res = RW'(lw);
            end
            default: res_valid = 1'b0;
        endcase
    end

    // Terminal count is judged on the value the counter is about to hold.
    always_comb begin
        if (bus.ld)
            cnt_nx = bus.in1;
        else if (bus.s == OP_UP)
            cnt_nx = cnt + W'(1);
        else
            cnt_nx = cnt - W'(1);
        tc_nx = (bus.s == OP_UP) ? (&cnt_nx) : (cnt_nx == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            iter      <= '0;
            bus.out   <= '0;
            bus.flags <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ld && bus.s == OP_MUL) begin
                        mcand    <= a_ext;
                        mplier   <= bus.in2;
                        acc      <= '0;
                        iter     <= CW'(W);
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else if (is_cnt) begin
                        cnt       <= cnt_nx;
                        bus.out   <= cnt_out;
                        bus.flags <= {1'b0, tc_nx, cnt_out == '0, 1'b0};
                    end else if (bus.ld) begin
                        if (res_valid) begin
                            bus.out   <= res;
                            bus.flags <= {1'b0, res_c, res == '0, res_eq};
                        end else begin
                            bus.flags[3] <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // W partial-product steps, then one edge to publish the product.
                    if (iter == '0) begin
                        bus.out   <= acc;
                        bus.flags <= {2'b00, acc == '0, 1'b0};
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (mplier[0])
                            acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        iter   <= iter - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
